// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 pipeline: op encoding, opcodes,
// and the ID/EX register layout.
package cpu_pkg;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam logic [AW-1:0] XZR = 5'd31;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_ADDI = 4'd3,
        OP_LDUR = 4'd4,
        OP_STUR = 4'd5,
        OP_CBZ  = 4'd6,
        OP_B    = 4'd7
    } op_t;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [5:0]  OPC_B    = 6'b000101;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        op_t           op;
        logic [DW-1:0] opa;
        logic [DW-1:0] opb;
        logic [DW-1:0] imm;
        logic [AW-1:0] dst;
        logic          reg_write;
        logic          is_load;
    } idex_t;

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage pipeline connections: IF/ID input, regfile read port,
// EX/MEM/WB forwarding sources and the ID/EX register outputs.
interface id_stage_if #(
    parameter int DW = 64,
    parameter int AW = 5
) ();
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [DW-1:0] if_pc;
    logic          id_ready;

    logic [AW-1:0] rf_rd_reg1;
    logic [AW-1:0] rf_rd_reg2;
    logic [DW-1:0] rf_rd_data1;
    logic [DW-1:0] rf_rd_data2;

    logic          ex_ready;
    logic [DW-1:0] ex_alu_result;
    logic          flush;
    logic          mem_reg_write;
    logic [AW-1:0] mem_dst;
    logic [DW-1:0] mem_fwd_data;
    logic          wb_reg_write;
    logic [AW-1:0] wb_dst;
    logic [DW-1:0] wb_data;

    logic          idex_valid;
    logic [DW-1:0] idex_pc;
    cpu_pkg::op_t  idex_op;
    logic [DW-1:0] idex_opa;
    logic [DW-1:0] idex_opb;
    logic [DW-1:0] idex_imm;
    logic [AW-1:0] idex_dst;
    logic          idex_reg_write;
    logic          idex_is_load;

    modport master (
        output if_valid, if_instr, if_pc, rf_rd_data1, rf_rd_data2,
               ex_ready, ex_alu_result, flush, mem_reg_write, mem_dst, mem_fwd_data,
               wb_reg_write, wb_dst, wb_data,
        input  id_ready, rf_rd_reg1, rf_rd_reg2, idex_valid, idex_pc, idex_op,
               idex_opa, idex_opb, idex_imm, idex_dst, idex_reg_write, idex_is_load
    );

    modport slave (
        input  if_valid, if_instr, if_pc, rf_rd_data1, rf_rd_data2,
               ex_ready, ex_alu_result, flush, mem_reg_write, mem_dst, mem_fwd_data,
               wb_reg_write, wb_dst, wb_data,
        output id_ready, rf_rd_reg1, rf_rd_reg2, idex_valid, idex_pc, idex_op,
               idex_opa, idex_opb, idex_imm, idex_dst, idex_reg_write, idex_is_load
    );
endinterface

// File: rtl/instr_decode.sv
// Combinational LEGv8 decoder: opcode class, register sources with use flags,
// destination and extended immediate. Unused register fields read as XZR.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [31:0]   instr_i,
    output op_t           op_o,
    output logic [AW-1:0] src1_o,
    output logic [AW-1:0] src2_o,
    output logic          uses1_o,
    output logic          uses2_o,
    output logic [AW-1:0] dst_o,
    output logic [DW-1:0] imm_o
);
    logic [AW-1:0] rd, rn, rm;

    assign rd = instr_i[4:0];
    assign rn = instr_i[9:5];
    assign rm = instr_i[20:16];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        op_o    = OP_NOP;
        src1_o  = XZR;
        src2_o  = XZR;
        uses1_o = 1'b0;
        uses2_o = 1'b0;
        dst_o   = XZR;
        imm_o   = '0;

        if (instr_i[31:21] == OPC_ADD || instr_i[31:21] == OPC_SUB) begin
            op_o    = (instr_i[31:21] == OPC_ADD) ? OP_ADD : OP_SUB;
            src1_o  = rn;
            uses1_o = 1'b1;
            src2_o  = rm;
            uses2_o = 1'b1;
            dst_o   = rd;
        end else if (instr_i[31:22] == OPC_ADDI) begin
            op_o    = OP_ADDI;
            src1_o  = rn;
            uses1_o = 1'b1;
            dst_o   = rd;
            imm_o   = {{(DW-12){1'b0}}, instr_i[21:10]};
        end else if (instr_i[31:21] == OPC_LDUR || instr_i[31:21] == OPC_STUR) begin
            src1_o  = rn;
            uses1_o = 1'b1;
            imm_o   = {{(DW-9){instr_i[20]}}, instr_i[20:12]};
            if (instr_i[31:21] == OPC_LDUR) begin
                op_o  = OP_LDUR;
                dst_o = rd;
            end else begin
                // Store data comes through the second read port.
                op_o    = OP_STUR;
                src2_o  = rd;
                uses2_o = 1'b1;
            end
        end else if (instr_i[31:24] == OPC_CBZ) begin
            op_o    = OP_CBZ;
            src1_o  = rd;
            uses1_o = 1'b1;
            imm_o   = {{(DW-21){instr_i[23]}}, instr_i[23:5], 2'b00};
        end else if (instr_i[31:26] == OPC_B) begin
            op_o  = OP_B;
            imm_o = {{(DW-28){instr_i[25]}}, instr_i[25:0], 2'b00};
        end
    end
endmodule

// File: rtl/id_stage.sv
// LEGv8 decode stage: operand forwarding from EX/MEM/WB, load-use stall,
// and the ID/EX pipeline register.
module id_stage
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    id_stage_if.slave bus
);
    op_t           dec_op;
    logic [AW-1:0] dec_src1, dec_src2, dec_dst;
    logic          dec_uses1, dec_uses2;
    logic [DW-1:0] dec_imm;
    logic          dec_valid;
    logic          load_use, hold;
    idex_t         idex_q, idex_d;

    instr_decode u_decode (
        .instr_i (bus.if_instr),
        .op_o    (dec_op),
        .src1_o  (dec_src1),
        .src2_o  (dec_src2),
        .uses1_o (dec_uses1),
        .uses2_o (dec_uses2),
        .dst_o   (dec_dst),
        .imm_o   (dec_imm)
    );

    // Youngest producer wins; loads in ID/EX have no data yet and stall instead.
    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] src, input logic [DW-1:0] rf_data);
        if (src == XZR)
            return '0;
        else if (idex_q.valid && idex_q.reg_write && idex_q.dst == src && !idex_q.is_load)
            return bus.ex_alu_result;
        else if (bus.mem_reg_write && bus.mem_dst == src)
            return bus.mem_fwd_data;
        else if (bus.wb_reg_write && bus.wb_dst == src)
            return bus.wb_data;
        else
            return rf_data;
    endfunction

    assign dec_valid = bus.if_valid && (dec_op != OP_NOP);
    assign load_use  = idex_q.valid && idex_q.is_load && (idex_q.dst != XZR) &&
                       ((dec_uses1 && dec_src1 == idex_q.dst) ||
                        (dec_uses2 && dec_src2 == idex_q.dst));
    assign hold      = idex_q.valid && !bus.ex_ready;

    assign bus.id_ready   = bus.flush || (!load_use && !hold);
    assign bus.rf_rd_reg1 = dec_src1;
    assign bus.rf_rd_reg2 = dec_src2;

    always_comb begin
        idex_d = idex_q;
        if (bus.flush || (!hold && load_use)) begin
            idex_d.valid     = 1'b0;
            idex_d.reg_write = 1'b0;
            idex_d.is_load   = 1'b0;
        end else if (!hold) begin
            idex_d.valid     = dec_valid;
            idex_d.pc        = bus.if_pc;
            idex_d.op        = dec_op;
            idex_d.opa       = fwd(dec_src1, bus.rf_rd_data1);
            idex_d.opb       = fwd(dec_src2, bus.rf_rd_data2);
            idex_d.imm       = dec_imm;
            idex_d.dst       = dec_dst;
            idex_d.reg_write = dec_valid && (dec_dst != XZR);
            idex_d.is_load   = dec_valid && (dec_op == OP_LDUR);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset)
            idex_q <= '0;
        else
            idex_q <= idex_d;
    end

    assign bus.idex_valid     = idex_q.valid;
    assign bus.idex_pc        = idex_q.pc;
    assign bus.idex_op        = idex_q.op;
    assign bus.idex_opa       = idex_q.opa;
    assign bus.idex_opb       = idex_q.opb;
    assign bus.idex_imm       = idex_q.imm;
    assign bus.idex_dst       = idex_q.dst;
    assign bus.idex_reg_write = idex_q.reg_write;
    assign bus.idex_is_load   = idex_q.is_load;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: forwarding priority, load-use bubble, hold,
// flush, reset and immediate extension, against hand-computed values.
module tb_id_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [63:0] rf [32];

    id_stage_if #(.DW(64), .AW(5)) bus ();

    id_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file model; X31 holds junk so XZR handling is visible.
    always_comb bus.rf_rd_data1 = rf[bus.rf_rd_reg1];
    always_comb bus.rf_rd_data2 = rf[bus.rf_rd_reg2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%h expected=0x%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_add(input logic [4:0] rd, rn, rm);
        return {OPC_ADD, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_addi(input logic [4:0] rd, rn, input logic [11:0] imm);
        return {OPC_ADDI, imm, rn, rd};
    endfunction
    function automatic logic [31:0] enc_ldur(input logic [4:0] rt, rn, input logic [8:0] imm);
        return {OPC_LDUR, imm, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_stur(input logic [4:0] rt, rn, input logic [8:0] imm);
        return {OPC_STUR, imm, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_cbz(input logic [4:0] rt, input logic [18:0] imm);
        return {OPC_CBZ, imm, rt};
    endfunction
    function automatic logic [31:0] enc_b(input logic [25:0] imm);
        return {OPC_B, imm};
    endfunction

    task automatic issue(input logic [31:0] instr, input logic [63:0] pc);
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_pc    = pc;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid"}, 64'(bus.idex_valid), 64'd0);
        chk({tag, "_op"},    64'(bus.idex_op), 64'(OP_NOP));
        chk({tag, "_pc"},    bus.idex_pc, 64'd0);
        chk({tag, "_opa"},   bus.idex_opa, 64'd0);
        chk({tag, "_opb"},   bus.idex_opb, 64'd0);
        chk({tag, "_imm"},   bus.idex_imm, 64'd0);
        chk({tag, "_dst"},   64'(bus.idex_dst), 64'd0);
        chk({tag, "_rw"},    64'(bus.idex_reg_write), 64'd0);
        chk({tag, "_ld"},    64'(bus.idex_is_load), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 64'h1000 + 64'(i);
        rf[0]  = 64'h10;
        rf[2]  = 64'd5;
        rf[3]  = 64'd7;
        rf[4]  = 64'h777;
        rf[6]  = 64'h555;
        rf[9]  = 64'h1;
        rf[31] = 64'hDEAD;

        reset = 1'b1;
        bus.if_valid = 1'b0;      bus.if_instr = 32'd0;      bus.if_pc = 64'd0;
        bus.ex_ready = 1'b1;      bus.ex_alu_result = 64'd0; bus.flush = 1'b0;
        bus.mem_reg_write = 1'b0; bus.mem_dst = 5'd0;        bus.mem_fwd_data = 64'd0;
        bus.wb_reg_write = 1'b0;  bus.wb_dst = 5'd0;         bus.wb_data = 64'd0;
        step();
        step();
        check_cleared("reset");
        reset = 1'b0;

        // ADD X1,X2,X3 straight from the regfile.
        issue(enc_add(5'd1, 5'd2, 5'd3), 64'h100);
        #1;
        chk("add_ready", 64'(bus.id_ready), 64'd1);
        chk("add_rreg1", 64'(bus.rf_rd_reg1), 64'd2);
        chk("add_rreg2", 64'(bus.rf_rd_reg2), 64'd3);
        step();
        chk("add_valid", 64'(bus.idex_valid), 64'd1);
        chk("add_op",    64'(bus.idex_op), 64'(OP_ADD));
        chk("add_opa",   bus.idex_opa, 64'd5);
        chk("add_opb",   bus.idex_opb, 64'd7);
        chk("add_dst",   64'(bus.idex_dst), 64'd1);
        chk("add_rw",    64'(bus.idex_reg_write), 64'd1);
        chk("add_pc",    bus.idex_pc, 64'h100);

        // EX forwarding beats MEM for X4.
        issue(enc_add(5'd4, 5'd2, 5'd3), 64'h104);
        step();
        bus.ex_alu_result = 64'h2A;
        bus.mem_reg_write = 1'b1; bus.mem_dst = 5'd4; bus.mem_fwd_data = 64'h33;
        issue(enc_add(5'd5, 5'd4, 5'd4), 64'h108);
        #1;
        chk("exfwd_ready", 64'(bus.id_ready), 64'd1);
        step();
        chk("exfwd_opa", bus.idex_opa, 64'h2A);
        chk("exfwd_opb", bus.idex_opb, 64'h2A);
        chk("exfwd_dst", 64'(bus.idex_dst), 64'd5);
        bus.mem_reg_write = 1'b0;

        // Load-use: LDUR X6 then ADD X7,X6,X0 -> one bubble, then MEM forward.
        issue(enc_ldur(5'd6, 5'd2, 9'd16), 64'h10C);
        step();
        chk("ldur_isload", 64'(bus.idex_is_load), 64'd1);
        chk("ldur_imm",    bus.idex_imm, 64'd16);
        chk("ldur_op",     64'(bus.idex_op), 64'(OP_LDUR));
        issue(enc_add(5'd7, 5'd6, 5'd0), 64'h110);
        #1;
        chk("lu_ready", 64'(bus.id_ready), 64'd0);
        step();
        chk("lu_bubble_valid", 64'(bus.idex_valid), 64'd0);
        chk("lu_bubble_rw",    64'(bus.idex_reg_write), 64'd0);
        bus.mem_reg_write = 1'b1; bus.mem_dst = 5'd6; bus.mem_fwd_data = 64'h99;
        bus.wb_reg_write  = 1'b1; bus.wb_dst  = 5'd6; bus.wb_data      = 64'hBAD;
        #1;
        chk("lu_release_ready", 64'(bus.id_ready), 64'd1);
        step();
        chk("lu_memfwd_opa", bus.idex_opa, 64'h99);
        chk("lu_opb",        bus.idex_opb, 64'h10);
        chk("lu_valid",      64'(bus.idex_valid), 64'd1);
        chk("lu_dst",        64'(bus.idex_dst), 64'd7);
        bus.mem_reg_write = 1'b0;

        // WB forwarding for X9 (regfile still old), max zero-extended ADDI immediate.
        bus.wb_dst = 5'd9; bus.wb_data = 64'h1234;
        issue(enc_addi(5'd10, 5'd9, 12'hFFF), 64'h114);
        #1;
        chk("addi_rreg2", 64'(bus.rf_rd_reg2), 64'd31);
        step();
        chk("wbfwd_opa", bus.idex_opa, 64'h1234);
        chk("addi_imm",  bus.idex_imm, 64'hFFF);
        chk("addi_op",   64'(bus.idex_op), 64'(OP_ADDI));
        bus.wb_dst = 5'd31; bus.wb_data = 64'h5555;
        issue(enc_addi(5'd10, 5'd31, 12'd1), 64'h200);
        step();
        chk("xzr_opa", bus.idex_opa, 64'd0);
        bus.wb_reg_write = 1'b0;

        // EX stalls for 3 cycles: ID/EX frozen, IF stalled.
        bus.ex_ready = 1'b0;
        issue(enc_add(5'd11, 5'd2, 5'd3), 64'h300);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", 64'(bus.id_ready), 64'd0);
            step();
            chk("hold_valid", 64'(bus.idex_valid), 64'd1);
            chk("hold_pc",    bus.idex_pc, 64'h200);
            chk("hold_imm",   bus.idex_imm, 64'd1);
            chk("hold_dst",   64'(bus.idex_dst), 64'd10);
        end
        bus.flush = 1'b1;
        #1;
        chk("flush_ready", 64'(bus.id_ready), 64'd1);
        step();
        chk("flush_valid", 64'(bus.idex_valid), 64'd0);
        bus.flush = 1'b0;
        bus.ex_ready = 1'b1;

        // Flush and load-use together: flush wins.
        issue(enc_ldur(5'd6, 5'd2, 9'd16), 64'h304);
        step();
        issue(enc_add(5'd7, 5'd6, 5'd0), 64'h308);
        bus.flush = 1'b1;
        #1;
        chk("flush_lu_ready", 64'(bus.id_ready), 64'd1);
        step();
        chk("flush_lu_valid", 64'(bus.idex_valid), 64'd0);
        bus.flush = 1'b0;

        // Reset during a load-use stall.
        issue(enc_ldur(5'd6, 5'd2, 9'd16), 64'h30C);
        step();
        issue(enc_add(5'd7, 5'd6, 5'd0), 64'h310);
        #1;
        chk("rst_lu_ready", 64'(bus.id_ready), 64'd0);
        reset = 1'b1;
        step();
        check_cleared("rst_lu");
        reset = 1'b0;

        // STUR X31,[X2,#-8]: store data is XZR, negative offset.
        issue(enc_stur(5'd31, 5'd2, 9'h1F8), 64'h400);
        #1;
        chk("stur_rreg2", 64'(bus.rf_rd_reg2), 64'd31);
        step();
        chk("stur_opb", bus.idex_opb, 64'd0);
        chk("stur_imm", bus.idex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("stur_opa", bus.idex_opa, 64'd5);
        chk("stur_rw",  64'(bus.idex_reg_write), 64'd0);
        chk("stur_op",  64'(bus.idex_op), 64'(OP_STUR));

        // CBZ X3 reads Rt through port 1; offset -1 word.
        issue(enc_cbz(5'd3, 19'h7FFFF), 64'h404);
        #1;
        chk("cbz_rreg1", 64'(bus.rf_rd_reg1), 64'd3);
        step();
        chk("cbz_opa", bus.idex_opa, 64'd7);
        chk("cbz_imm", bus.idex_imm, 64'hFFFF_FFFF_FFFF_FFFC);

        // B: no sources, positive offset.
        issue(enc_b(26'd1), 64'h408);
        step();
        chk("b_op",  64'(bus.idex_op), 64'(OP_B));
        chk("b_imm", bus.idex_imm, 64'd4);
        chk("b_opa", bus.idex_opa, 64'd0);

        // Unknown encoding captured as invalid NOP.
        issue(32'd0, 64'h40C);
        step();
        chk("unk_valid", 64'(bus.idex_valid), 64'd0);
        chk("unk_op",    64'(bus.idex_op), 64'(OP_NOP));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
